hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised load-use hazard and control-flush unit for the in-order 5-stage pipeline. It tracks loads in flight across a configurable number of load-latency stages, not only the ID/EX load. It stalls the IF/ID stage and bubbles ID/EX while a consumer in ID depends on any pending load. Taken branches resolved in EX flush IF/ID and bubble ID/EX; the flush has priority over the stall.

Parameters:
REG_ADDR_W, 5, register-index width
LOAD_LAT, 1, cycles from load in EX until its data is forwardable; legal range 1..4; 1 means only the ID/EX load can cause a stall
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
idex_memread  in  1  the instruction in EX is a load
idex_rd  in  REG_ADDR_W  destination register of the EX instruction
ifid_rs1  in  REG_ADDR_W  source register 1 of the ID instruction
ifid_rs2  in  REG_ADDR_W  source register 2 of the ID instruction
ifid_uses_rs1  in  1  ID instruction actually reads rs1
ifid_uses_rs2  in  1  ID instruction actually reads rs2
ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle
stall  out  1  load-use stall (combinational)
pc_write  out  1  PC update enable (= !stall)
ifid_write  out  1  IF/ID register enable (= !stall)
idex_bubble  out  1  zero the ID/EX control bits (= stall | ex_branch_taken)
flush_ifid  out  1  invalidate IF/ID (= ex_branch_taken)
busy_state  out  1  FSM state: 0=RUN, 1=STALL (registered)
stall_cycles  out  CNT_W  total stalled cycles (feature only)
load_use_events  out  CNT_W  number of RUN->STALL entries (feature only)

Behaviour:
- Reset: all pending entries invalid, FSM=RUN, counters=0. Combinational outputs follow their equations; with idle inputs: stall=0, pc_write=1, ifid_write=1, idex_bubble=0, flush_ifid=0.
- Pending pipe: entries pend[1..LOAD_LAT-1], each holding {valid, rd}. None exist when LOAD_LAT=1.
  - Each clk: pend[1] <= {idex_memread && idex_rd!=0, idex_rd}; pend[k+1] <= pend[k].
  - EX always advances. Stall and flush never hold or clear pending entries, because those loads are older than the branch.
- Match: stage 0 = {idex_memread && idex_rd!=0, idex_rd}, plus every pend[k]. A source matches when its uses flag=1, rs!=0, and it equals the rd of a valid stage.
- stall = (rs1 match | rs2 match) & !ex_branch_taken. Flush wins because the dependent ID instruction is being killed.
- Register x0 never causes a stall.
- Worst-case stall length for a single load is LOAD_LAT cycles. Back-to-back loads extend the stall naturally.
- FSM:
  - RUN -> STALL when stall=1.
  - STALL -> RUN when stall=0.
  - STALL -> STALL while stall=1.
- Simultaneous events:
  - Branch taken plus hazard: stall=0, flush_ifid=1, idex_bubble=1.
  - Load in EX with a consumer in ID at the same rd: stall on the same cycle.
- Reset mid-stall: pending pipe is cleared asynchronously, so stall drops immediately unless stage 0 still matches.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments on every clk with stall=1. load_use_events increments on each RUN->STALL transition. Both saturate at all-ones and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are synthesised.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_ADDR_W default
  - REG_X0 = 0 constant
  - state typedef {ST_RUN, ST_STALL}
  - LOAD_LAT_MAX = 4
- One sub-module is natural: hazard_pend_pipe (parametrised {valid, rd} shift register of depth LOAD_LAT-1). It exposes flattened valid/rd vectors and generates empty when depth=0.

Test Plan:
1. LOAD_LAT=1; idex_memread=1, idex_rd=5, ifid_rs1=5, uses_rs1=1 -> same cycle stall=1, pc_write=0, ifid_write=0, idex_bubble=1. Next cycle memread=0 -> stall=0, busy_state returns to RUN.
2. idex_memread=1, idex_rd=0, ifid_rs1=0, uses_rs1=1 -> stall=0. Then idex_rd=9, ifid_rs2=9, uses_rs2=0 -> stall=0.
3. LOAD_LAT=3; load rd=7 in EX at cycle 0, then no further loads; ID holds rs1=7 -> stall=1 on cycles 0,1,2 and stall=0 on cycle 3. With the feature enabled: stall_cycles=3, load_use_events=1.
4. Hazard as in 1 plus ex_branch_taken=1 -> stall=0, flush_ifid=1, idex_bubble=1, pc_write=1.
5. LOAD_LAT=2; load rd=3 enters pend[1]; assert reset mid-cycle -> pend cleared asynchronously, stall=0 with rs1=3 and idex_memread=0, counters=0.
6. CNT_W=4, feature enabled; hold a hazard for 20 cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_X0         = 0;
  localparam int LOAD_LAT_MAX   = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_pend_pipe.sv
// Shift register of {valid, rd} for loads still waiting on their data.
// When DEPTH is 0 it holds no state and its outputs are tied to zero.
module hazard_pend_pipe #(
  parameter  int REG_ADDR_W = 5,
  parameter  int DEPTH      = 0,
  localparam int VW         = (DEPTH > 0) ? DEPTH : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  output logic [VW-1:0]            valid_o,
  output logic [VW*REG_ADDR_W-1:0] rd_o
);

  if (DEPTH == 0) begin : g_empty
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, in_valid, in_rd};
    assign valid_o = '0;
    assign rd_o    = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d [DEPTH];

    always_comb begin
      valid_d[0] = in_valid;
      rd_d[0]    = in_rd;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= '0;
        for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
      end else begin
        valid_q <= valid_d;
        for (int k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
      end
    end

    always_comb begin
      valid_o = valid_q;
      for (int k = 0; k < DEPTH; k++) rd_o[k*REG_ADDR_W +: REG_ADDR_W] = rd_q[k];
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use stall and branch-flush unit tracking loads across LOAD_LAT stages.
// Optional saturating perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs1,
  input  logic                  ifid_uses_rs2,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  flush_ifid,
  output logic                  busy_state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      load_use_events
);

  localparam int DEPTH  = LOAD_LAT - 1;
  localparam int PEND_W = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  logic                         s0_valid;
  logic [PEND_W-1:0]            pend_valid;
  logic [PEND_W*REG_ADDR_W-1:0] pend_rd;
  logic                         hit1, hit2, rs1_match, rs2_match;
  state_e                       state_q, state_d;

  assign s0_valid = idex_memread && (idex_rd != X0);

  hazard_pend_pipe #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH)
  ) u_pend (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s0_valid),
    .in_rd    (idex_rd),
    .valid_o  (pend_valid),
    .rd_o     (pend_rd)
  );

  // A source hits if any in-flight load (EX or pending) targets it.
  always_comb begin
    hit1 = s0_valid && (idex_rd == ifid_rs1);
    hit2 = s0_valid && (idex_rd == ifid_rs2);
    for (int k = 0; k < PEND_W; k++) begin
      if (pend_valid[k] && (pend_rd[k*REG_ADDR_W +: REG_ADDR_W] == ifid_rs1)) hit1 = 1'b1;
      if (pend_valid[k] && (pend_rd[k*REG_ADDR_W +: REG_ADDR_W] == ifid_rs2)) hit2 = 1'b1;
    end
    rs1_match = ifid_uses_rs1 && (ifid_rs1 != X0) && hit1;
    rs2_match = ifid_uses_rs2 && (ifid_rs2 != X0) && hit2;
  end

  // The consumer is killed by a taken branch, so the flush overrides the stall.
  assign stall       = (rs1_match || rs2_match) && !ex_branch_taken;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall || ex_branch_taken;
  assign flush_ifid  = ex_branch_taken;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall)  state_d = ST_STALL;
      ST_STALL: if (!stall) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  assign busy_state = (state_q == ST_STALL);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] events_q, events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    events_d       = events_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (stall && (state_q == ST_RUN) && (events_q != '1)) events_d = events_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      events_q       <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      events_q       <= events_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = events_q;
`else
  assign stall_cycles    = '0;
  assign load_use_events = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at LOAD_LAT 1, 2 and 3 sharing one stimulus.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       idex_memread, ifid_uses_rs1, ifid_uses_rs2, ex_branch_taken;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;

  logic stall1, pcw1, ifw1, bub1, fl1, busy1;
  logic stall2, pcw2, ifw2, bub2, fl2, busy2;
  logic stall3, pcw3, ifw3, bub3, fl3, busy3;
  logic [31:0] sc1, ev1, sc2, ev2;
  logic [3:0]  sc3, ev3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs1(ifid_uses_rs1),
    .ifid_uses_rs2(ifid_uses_rs2), .ex_branch_taken(ex_branch_taken),
    .stall(stall1), .pc_write(pcw1), .ifid_write(ifw1), .idex_bubble(bub1),
    .flush_ifid(fl1), .busy_state(busy1), .stall_cycles(sc1), .load_use_events(ev1));

  hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs1(ifid_uses_rs1),
    .ifid_uses_rs2(ifid_uses_rs2), .ex_branch_taken(ex_branch_taken),
    .stall(stall2), .pc_write(pcw2), .ifid_write(ifw2), .idex_bubble(bub2),
    .flush_ifid(fl2), .busy_state(busy2), .stall_cycles(sc2), .load_use_events(ev2));

  hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs1(ifid_uses_rs1),
    .ifid_uses_rs2(ifid_uses_rs2), .ex_branch_taken(ex_branch_taken),
    .stall(stall3), .pc_write(pcw3), .ifid_write(ifw3), .idex_bubble(bub3),
    .flush_ifid(fl3), .busy_state(busy3), .stall_cycles(sc3), .load_use_events(ev3));

  task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic br);
    @(negedge clk);
    idex_memread    = mr;
    idex_rd         = rd;
    ifid_rs1        = rs1;
    ifid_rs2        = rs2;
    ifid_uses_rs1   = u1;
    ifid_uses_rs2   = u2;
    ex_branch_taken = br;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; ex_branch_taken = 0;
    #2;
    checkOutput("rst_stall",  {31'd0, stall1}, 0);
    checkOutput("rst_pcw",    {31'd0, pcw1},   1);
    checkOutput("rst_ifw",    {31'd0, ifw3},   1);
    checkOutput("rst_bubble", {31'd0, bub2},   0);
    checkOutput("rst_flush",  {31'd0, fl1},    0);
    checkOutput("rst_busy",   {31'd0, busy3},  0);
    checkOutput("rst_cnt",    sc1,             0);
    @(negedge clk);
    reset = 1'b0;

    // Single load to x7 with a consumer held in ID
    applyStimulus(1, 7, 7, 0, 1, 0, 0);
    checkOutput("ld_stall1",  {31'd0, stall1}, 1);
    checkOutput("ld_stall3",  {31'd0, stall3}, 1);
    checkOutput("ld_pcw1",    {31'd0, pcw1},   0);
    checkOutput("ld_ifw1",    {31'd0, ifw1},   0);
    checkOutput("ld_bubble1", {31'd0, bub1},   1);
    checkOutput("ld_flush1",  {31'd0, fl1},    0);
    applyStimulus(0, 0, 7, 0, 1, 0, 0);
    checkOutput("c1_stall1", {31'd0, stall1}, 0);
    checkOutput("c1_busy1",  {31'd0, busy1},  1);
    checkOutput("c1_stall2", {31'd0, stall2}, 1);
    checkOutput("c1_stall3", {31'd0, stall3}, 1);
    applyStimulus(0, 0, 7, 0, 1, 0, 0);
    checkOutput("c2_busy1",  {31'd0, busy1},  0);
    checkOutput("c2_stall2", {31'd0, stall2}, 0);
    checkOutput("c2_busy2",  {31'd0, busy2},  1);
    checkOutput("c2_stall3", {31'd0, stall3}, 1);
    applyStimulus(0, 0, 7, 0, 1, 0, 0);
    checkOutput("c3_stall3", {31'd0, stall3}, 0);
    checkOutput("c3_busy3",  {31'd0, busy3},  1);
    checkOutput("c3_busy2",  {31'd0, busy2},  0);
    applyStimulus(0, 0, 7, 0, 1, 0, 0);
    checkOutput("c4_busy3", {31'd0, busy3}, 0);
    checkOutput("cnt_sc1",  sc1,            PERF ? 1 : 0);
    checkOutput("cnt_sc2",  sc2,            PERF ? 2 : 0);
    checkOutput("cnt_sc3",  {28'd0, sc3},   PERF ? 3 : 0);
    checkOutput("cnt_ev3",  {28'd0, ev3},   PERF ? 1 : 0);

    // x0 never stalls; an unused source never stalls
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("x0_stall1", {31'd0, stall1}, 0);
    checkOutput("x0_stall3", {31'd0, stall3}, 0);
    applyStimulus(1, 9, 0, 9, 0, 0, 0);
    checkOutput("nouse_stall1", {31'd0, stall1}, 0);
    checkOutput("nouse_stall3", {31'd0, stall3}, 0);

    // Taken branch overrides a hazard but keeps pending loads
    applyStimulus(1, 5, 5, 0, 1, 0, 1);
    checkOutput("br_stall1",  {31'd0, stall1}, 0);
    checkOutput("br_flush1",  {31'd0, fl1},    1);
    checkOutput("br_bubble1", {31'd0, bub1},   1);
    checkOutput("br_pcw1",    {31'd0, pcw1},   1);
    checkOutput("br_stall3",  {31'd0, stall3}, 0);
    applyStimulus(0, 0, 5, 0, 1, 0, 0);
    checkOutput("brp_stall1", {31'd0, stall1}, 0);
    checkOutput("brp_stall2", {31'd0, stall2}, 1);
    checkOutput("brp_stall3", {31'd0, stall3}, 1);
    checkOutput("brp_flush2", {31'd0, fl2},    0);

    // rs2 path and asynchronous reset while a load is pending
    applyStimulus(1, 3, 0, 0, 0, 0, 0);
    checkOutput("r_busy2",  {31'd0, busy2},  1);
    checkOutput("r_stall2", {31'd0, stall2}, 0);
    applyStimulus(0, 0, 0, 3, 0, 1, 0);
    checkOutput("rs2_stall2", {31'd0, stall2}, 1);
    checkOutput("rs2_stall3", {31'd0, stall3}, 1);
    checkOutput("rs2_stall1", {31'd0, stall1}, 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("ar_stall2", {31'd0, stall2}, 0);
    checkOutput("ar_stall3", {31'd0, stall3}, 0);
    checkOutput("ar_busy2",  {31'd0, busy2},  0);
    checkOutput("ar_sc3",    {28'd0, sc3},    0);
    checkOutput("ar_ev2",    ev2,             0);
    #1 reset = 1'b0;

    // Long hazard: 4-bit counter saturates
    for (int i = 0; i < 20; i++) applyStimulus(1, 6, 6, 0, 1, 0, 0);
    checkOutput("long_stall3", {31'd0, stall3}, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_sc3", {28'd0, sc3}, PERF ? 15 : 0);
    checkOutput("sat_ev3", {28'd0, ev3}, PERF ? 1 : 0);
    checkOutput("sat_sc1", sc1,          PERF ? 20 : 0);
    checkOutput("sat_busy1", {31'd0, busy1}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
